imem_loader: RTL



---
 rtl/imem_loader_pkg.sv | 20 ++
 rtl/imem_word_asm.sv | 41 ++++
 rtl/imem_loader.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader:
// FSM state encoding, default frame sync marker and byte-index width.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_e;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Four bytes per 32-bit word.
    localparam int BYTE_IDX_W = 2;

endpackage

// File: rtl/imem_word_asm.sv
// Word assembler for the boot loader: packs four little-endian bytes into a
// 32-bit word, flags the byte that completes a word, and keeps a running XOR
// checksum of every byte shifted in since the last clear.
module imem_word_asm
    import imem_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_shift,
    input  logic [7:0]  i_byte,
    output logic        o_word_ready,
    output logic [31:0] o_word,
    output logic [7:0]  o_chk
);

    logic [23:0]           r_sr;
    logic [BYTE_IDX_W-1:0] r_idx;
    logic [7:0]            r_chk;

    // Shift bytes in from the top so byte0 ends up in the least significant lane.
    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_sr  <= '0;
            r_idx <= '0;
            r_chk <= '0;
        end else if (i_shift) begin
            r_sr  <= {i_byte, r_sr[23:8]};
            r_idx <= r_idx + 1'b1;
            r_chk <= r_chk ^ i_byte;
        end
    end

    // The completing byte is presented combinationally as the top lane.
    always_comb begin
        o_word_ready = i_shift && (r_idx == '1);
        o_word       = {i_byte, r_sr};
        o_chk        = r_chk;
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader. Parses a framed image from a UART byte
// stream (SYNC, LEN_LO, LEN_HI, 4*N payload bytes, XOR checksum), writes each
// assembled word to instruction memory and releases the core reset only once
// the whole image has loaded with a good checksum.
// Optional inter-byte timeout: define IMEM_LOADER_TIMEOUT_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_WIDTH     = 8,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    input  logic                  reload,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_reset,
    output logic                  load_done,
    output logic                  load_err,
    output logic [ADDR_WIDTH:0]   word_count
);

    // Largest legal word count is the full memory capacity.
    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

    state_e                r_state;
    state_e                w_state_next;

    logic [7:0]            r_len_lo;
    logic [ADDR_WIDTH:0]   r_len;
    logic [ADDR_WIDTH:0]   r_word_count;
    logic                  r_imem_we;
    logic [ADDR_WIDTH-1:0] r_imem_addr;
    logic [31:0]           r_imem_wdata;
    logic                  r_cpu_reset;
    logic                  r_load_done;
    logic                  r_load_err;

    logic                  w_accept;
    logic                  w_sync_hit;
    logic [15:0]           w_len16;
    logic                  w_len_over;
    logic                  w_len_zero;
    logic [ADDR_WIDTH:0]   w_wc_inc;
    logic                  w_last_word;
    logic                  w_shift;
    logic                  w_clear;
    logic                  w_word_ready;
    logic [31:0]           w_word;
    logic [7:0]            w_chk;
    logic                  w_timeout;
    logic                  w_cpu_reset_next;
    logic                  w_load_done_next;
    logic                  w_load_err_next;

    // A byte only counts when reload is not competing with it.
    always_comb begin
        w_accept    = rx_valid && !reload;
        w_sync_hit  = w_accept && (r_state == ST_IDLE) && (rx_data == SYNC_BYTE);
        w_len16     = {rx_data, r_len_lo};
        w_len_over  = {1'b0, w_len16} > MAX_WORDS;
        w_len_zero  = (w_len16 == 16'd0);
        w_wc_inc    = r_word_count + 1'b1;
        w_last_word = (w_wc_inc == r_len);
        w_shift     = w_accept && (r_state == ST_DATA);
        w_clear     = reload || w_sync_hit;
    end

    imem_word_asm u_word_asm (
        .clock        (clock),
        .reset        (reset),
        .i_clear      (w_clear),
        .i_shift      (w_shift),
        .i_byte       (rx_data),
        .o_word_ready (w_word_ready),
        .o_word       (w_word),
        .o_chk        (w_chk)
    );

`ifdef IMEM_LOADER_TIMEOUT_EN
    logic [31:0] r_tmo_cnt;
    logic        w_tmo_active;

    // Timeout applies only while a frame is in progress.
    always_comb begin
        w_tmo_active = (r_state == ST_LEN_LO) || (r_state == ST_LEN_HI) ||
                       (r_state == ST_DATA)   || (r_state == ST_CHECK);
        w_timeout    = w_tmo_active && !w_accept &&
                       (r_tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
    end

    // Idle-cycle counter, restarted by every accepted byte.
    always_ff @(posedge clock) begin
        if (reset || w_accept || !w_tmo_active) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end
`else
    logic w_unused_tmo;

    // Without the timeout the loader waits indefinitely for the next byte.
    always_comb begin
        w_timeout    = 1'b0;
        w_unused_tmo = (TIMEOUT_CYCLES == 0);
    end
`endif

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic; reload overrides everything.
    always_comb begin
        w_state_next = r_state;
        if (reload) begin
            w_state_next = ST_IDLE;
        end else if (w_timeout) begin
            w_state_next = ST_ERROR;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_sync_hit) w_state_next = ST_LEN_LO;
                end
                ST_LEN_LO: begin
                    if (w_accept) w_state_next = ST_LEN_HI;
                end
                ST_LEN_HI: begin
                    if (w_accept) begin
                        if (w_len_over)      w_state_next = ST_ERROR;
                        else if (w_len_zero) w_state_next = ST_CHECK;
                        else                 w_state_next = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_word_ready && w_last_word) w_state_next = ST_CHECK;
                end
                ST_CHECK: begin
                    if (w_accept) begin
                        w_state_next = (rx_data == w_chk) ? ST_DONE : ST_ERROR;
                    end
                end
                ST_DONE:  w_state_next = ST_DONE;
                ST_ERROR: w_state_next = ST_ERROR;
                default:  w_state_next = ST_IDLE;
            endcase
        end
    end

    // FSM output decode from the upcoming state so the status flags are registered.
    always_comb begin
        w_cpu_reset_next = (w_state_next != ST_DONE);
        w_load_done_next = (w_state_next == ST_DONE);
        w_load_err_next  = (w_state_next == ST_ERROR);
    end

    // Status output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cpu_reset <= 1'b1;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_cpu_reset <= w_cpu_reset_next;
            r_load_done <= w_load_done_next;
            r_load_err  <= w_load_err_next;
        end
    end

    // Length capture, word counter and the one-cycle imem write register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_len_lo     <= '0;
            r_len        <= '0;
            r_word_count <= '0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
        end else begin
            r_imem_we <= w_word_ready;
            if (w_word_ready) begin
                r_imem_addr  <= r_word_count[ADDR_WIDTH-1:0];
                r_imem_wdata <= w_word;
                r_word_count <= w_wc_inc;
            end
            if (w_sync_hit) begin
                r_word_count <= '0;
            end
            if (w_accept && (r_state == ST_LEN_LO)) begin
                r_len_lo <= rx_data;
            end
            if (w_accept && (r_state == ST_LEN_HI)) begin
                r_len <= w_len16[ADDR_WIDTH:0];
            end
        end
    end

    always_comb begin
        imem_we    = r_imem_we;
        imem_addr  = r_imem_addr;
        imem_wdata = r_imem_wdata;
        cpu_reset  = r_cpu_reset;
        load_done  = r_load_done;
        load_err   = r_load_err;
        word_count = r_word_count;
    end

endmodule
